pipelined_chunk_adder: RTL and testbench
========================================

Name: pipelined_chunk_adder

Overview:
- Parametrised successor to the fixed 32-bit two-segment ripple adder.
- Splits a WIDTH-bit add/subtract into WIDTH/CHUNK chunk slices, one pipeline stage per slice, with the carry registered between stages.
- Accepts one operation per cycle under a valid/ready handshake with backpressure.
- Used wherever wide arithmetic must meet timing inside datapath blocks.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CHUNK, 16, bits added per stage. WIDTH % CHUNK != 0 is an elaboration error. NSTAGE = WIDTH/CHUNK is derived locally.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  synchronous reset, active-low
- in_valid  in  1  operands present
- in_ready  out  1  block accepts operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  0: a+b+cin; 1: a-b-cin
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result this cycle
- sum  out  WIDTH  result, modulo 2^WIDTH
- cout  out  1  raw carry out of MSB chunk (sub mode: 1 = no borrow)
- ovf  out  1  two's-complement signed overflow

Behaviour:
- One clock, clk. Reset is synchronous and active-low on resetn; no asynchronous reset paths.
- Reset (resetn=0 at a clk edge):
  - all stage valid bits cleared; out_valid=0, sum=0, cout=0, ovf=0
  - in-flight operations discarded, never emitted
  - in_ready follows its normal equation (1 while out_valid=0)
- Operand conditioning at accept:
  - b_eff = sub ? ~b : b
  - c0 = sub ? ~cin : cin
  - so sub computes a + ~b + ~cin = a - b - cin
- Global enable: en = ~out_valid | out_ready; in_ready = en.
  - in_ready is combinational from out_ready and out_valid.
- Transfer occurs when in_valid & in_ready.
- Stage k (0..NSTAGE-1), when en:
  - adds chunk k of a and b_eff plus the carry registered from stage k-1 (c0 for k=0)
  - registers the chunk-k sum, carry out, the untouched upper operand chunks, already-done lower sum chunks, and a valid bit
  - stage 0 valid loads in_valid & in_ready
- When en=0, every stage register holds; bubbles are not collapsed.
- Latency: out_valid rises exactly NSTAGE cycles after the accept edge when no stall occurs. Throughput is 1 op/cycle.
- Output:
  - sum, cout and ovf are the last stage registers
  - ovf = carry into MSB XOR carry out of MSB, computed in the last stage
  - while out_valid & ~out_ready, sum/cout/ovf/out_valid hold stable
- Ordering: results leave in acceptance order; none dropped or duplicated.
- NSTAGE=1 (CHUNK=WIDTH): a single registered adder with latency 1; same handshake.
- Simultaneous accept and emit in one cycle is allowed (full-rate streaming).
- Inputs are ignored when in_valid=0 or in_ready=0; a, b, cin and sub are sampled only at accept.

Test Plan:
1. Reset: resetn=0 for 3 cycles with in_valid=1, a=1, b=1 -> out_valid=0, sum=0, cout=0, ovf=0 throughout, and no result appears after release.
2. Chunk carry (WIDTH=32, CHUNK=16): a=0x0000FFFF, b=1, cin=0, sub=0 -> exactly 2 cycles after accept: sum=0x00010000, cout=0, ovf=0.
3. Wrap and overflow:
   - a=0xFFFFFFFF, b=1 -> sum=0, cout=1, ovf=0
   - a=0x7FFFFFFF, b=1 -> sum=0x80000000, cout=0, ovf=1
4. Subtract:
   - a=5, b=7, sub=1, cin=0 -> sum=0xFFFFFFFE, cout=0, ovf=0
   - a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, cout=1, ovf=1
   - a=10, b=3, sub=1, cin=1 -> sum=6, cout=1
5. Streaming with backpressure: 8 back-to-back ops a=i, b=i*0x10001 with out_ready pattern 1,0,1,0,... -> 8 results in order, equal to the reference model; sum stable during every stall cycle; in_ready=0 exactly when out_valid=1 and out_ready=0.
6. Reset mid-flight and parameter sweep:
   - accept 2 ops, pull resetn low for 1 cycle -> no out_valid afterwards
   - repeat scenarios 2-5 with (WIDTH=8, CHUNK=8), (WIDTH=24, CHUNK=8) and (WIDTH=32, CHUNK=4); latency must equal NSTAGE in each case

Source files
------------

// File: rtl/pipelined_chunk_adder.sv
// rtl/pipelined_chunk_adder.sv - chunk-sliced pipelined add/subtract with valid/ready backpressure
module pipelined_chunk_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NSTAGE = WIDTH / CHUNK;

   generate
      if (WIDTH % CHUNK != 0) begin : g_bad_chunk
         $error("pipelined_chunk_adder: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   // Per-stage registers: operands travel along so later chunks see their bits,
   // and the partial sum accumulates one chunk per stage.
   logic [WIDTH-1:0] a_q   [NSTAGE];
   logic [WIDTH-1:0] b_q   [NSTAGE];
   logic [WIDTH-1:0] s_q   [NSTAGE];
   logic             c_q   [NSTAGE];
   logic             v_q   [NSTAGE];
   logic             ovf_q;

   logic [WIDTH-1:0] a_n   [NSTAGE];
   logic [WIDTH-1:0] b_n   [NSTAGE];
   logic [WIDTH-1:0] s_n   [NSTAGE];
   logic             c_n   [NSTAGE];
   logic             v_n   [NSTAGE];
   logic             ovf_n;
   logic             en;

   // Whole pipeline advances together whenever the output slot is free or being drained.
   always_comb begin
      en = ~v_q[NSTAGE-1] | out_ready;
   end

   assign in_ready  = en;
   assign out_valid = v_q[NSTAGE-1];
   assign sum       = s_q[NSTAGE-1];
   assign cout      = c_q[NSTAGE-1];
   assign ovf       = ovf_q;

   // Next-state of every stage: add chunk k of the operands plus the carry from the stage before.
   always_comb begin
      logic [WIDTH-1:0] as;
      logic [WIDTH-1:0] bs;
      logic [WIDTH-1:0] ss;
      logic             cs;
      logic             vs;
      logic [CHUNK:0]   part;
      int               km1;
      ovf_n = 1'b0;
      for (int k = 0; k < NSTAGE; k++) begin
         km1 = (k == 0) ? 0 : k - 1;
         if (k == 0) begin
            // Subtract is folded into the first stage as a + ~b + ~cin.
            as = a;
            bs = sub ? ~b : b;
            cs = sub ? ~cin : cin;
            ss = '0;
            vs = in_valid;
         end else begin
            as = a_q[km1];
            bs = b_q[km1];
            cs = c_q[km1];
            ss = s_q[km1];
            vs = v_q[km1];
         end
         part = {1'b0, as[k*CHUNK +: CHUNK]} + {1'b0, bs[k*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, cs};
         ss[k*CHUNK +: CHUNK] = part[CHUNK-1:0];
         a_n[k] = as;
         b_n[k] = bs;
         s_n[k] = ss;
         c_n[k] = part[CHUNK];
         v_n[k] = vs;
         if (k == NSTAGE - 1) begin
            // Carry into the MSB is recovered from the MSB's own sum bit.
            ovf_n = (as[WIDTH-1] ^ bs[WIDTH-1] ^ ss[WIDTH-1]) ^ part[CHUNK];
         end
      end
   end

   // Stage registers: cleared on reset, otherwise shift only when the pipeline is enabled.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int k = 0; k < NSTAGE; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
            c_q[k] <= 1'b0;
            v_q[k] <= 1'b0;
         end
         ovf_q <= 1'b0;
      end else if (en) begin
         for (int k = 0; k < NSTAGE; k++) begin
            a_q[k] <= a_n[k];
            b_q[k] <= b_n[k];
            s_q[k] <= s_n[k];
            c_q[k] <= c_n[k];
            v_q[k] <= v_n[k];
         end
         ovf_q <= ovf_n;
      end
   end

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// tb/tb_pipelined_chunk_adder.sv - directed self-checking bench over four parameter sets
module tb_pipelined_chunk_adder;

   logic        clk;
   logic        resetn;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;
   logic        sub;
   logic [3:0]  iv;
   logic [3:0]  ordy;

   logic        ir0, ir1, ir2, ir3;
   logic        ov0, ov1, ov2, ov3;
   logic        co0, co1, co2, co3;
   logic        of0, of1, of2, of3;
   logic [31:0] sum0;
   logic [7:0]  sum1;
   logic [23:0] sum2;
   logic [31:0] sum3;

   int tests;
   int fails;

   pipelined_chunk_adder #(.WIDTH(32), .CHUNK(16)) dut0 (
      .clk(clk), .resetn(resetn), .in_valid(iv[0]), .in_ready(ir0),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(ov0), .out_ready(ordy[0]), .sum(sum0), .cout(co0), .ovf(of0));

   pipelined_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut1 (
      .clk(clk), .resetn(resetn), .in_valid(iv[1]), .in_ready(ir1),
      .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
      .out_valid(ov1), .out_ready(ordy[1]), .sum(sum1), .cout(co1), .ovf(of1));

   pipelined_chunk_adder #(.WIDTH(24), .CHUNK(8)) dut2 (
      .clk(clk), .resetn(resetn), .in_valid(iv[2]), .in_ready(ir2),
      .a(a[23:0]), .b(b[23:0]), .cin(cin), .sub(sub),
      .out_valid(ov2), .out_ready(ordy[2]), .sum(sum2), .cout(co2), .ovf(of2));

   pipelined_chunk_adder #(.WIDTH(32), .CHUNK(4)) dut3 (
      .clk(clk), .resetn(resetn), .in_valid(iv[3]), .in_ready(ir3),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(ov3), .out_ready(ordy[3]), .sum(sum3), .cout(co3), .ovf(of3));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // {in_ready, out_valid, cout, ovf, sum zero-extended}
   function automatic logic [35:0] obs(input int d);
      case (d)
         0:       obs = {ir0, ov0, co0, of0, sum0};
         1:       obs = {ir1, ov1, co1, of1, 24'b0, sum1};
         2:       obs = {ir2, ov2, co2, of2, 8'b0, sum2};
         default: obs = {ir3, ov3, co3, of3, sum3};
      endcase
   endfunction

   function automatic int wid(input int d);
      case (d)
         0: wid = 32;
         1: wid = 8;
         2: wid = 24;
         default: wid = 32;
      endcase
   endfunction

   function automatic int nst(input int d);
      case (d)
         0: nst = 2;
         1: nst = 1;
         2: nst = 3;
         default: nst = 8;
      endcase
   endfunction

   // Reference: {ovf, cout, sum} for a w-bit add/subtract.
   function automatic logic [33:0] mdl(input int w, input logic [31:0] aa, input logic [31:0] bb,
                                       input logic ci, input logic su);
      logic [63:0] mask, am, be, full, s;
      logic        c0, co, cm;
      mask = (64'd1 << w) - 64'd1;
      am   = {32'b0, aa} & mask;
      be   = (su ? ~{32'b0, bb} : {32'b0, bb}) & mask;
      c0   = su ? ~ci : ci;
      full = am + be + {63'b0, c0};
      s    = full & mask;
      co   = full[w];
      cm   = am[w-1] ^ be[w-1] ^ s[w-1];
      mdl  = {cm ^ co, co, s[31:0]};
   endfunction

   task automatic test_reset();
      logic [35:0] o;
      resetn = 1'b0;
      iv     = 4'hF;
      ordy   = 4'hF;
      a      = 32'd1;
      b      = 32'd1;
      cin    = 1'b0;
      sub    = 1'b0;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         for (int d = 0; d < 4; d++) begin
            o = obs(d);
            tests++;
            if (o[35:0] !== {1'b1, 3'b000, 32'h0}) begin
               fails++;
               $display("FAIL reset_state dut%0d: got %h, expected %h", d, o, {1'b1, 35'h0});
            end
         end
      end
      resetn = 1'b1;
      iv     = 4'h0;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         for (int d = 0; d < 4; d++) begin
            o = obs(d);
            tests++;
            if (o[34] !== 1'b0) begin
               fails++;
               $display("FAIL reset_release_no_result dut%0d t=%0d: out_valid %b, expected 0", d, t, o[34]);
            end
         end
      end
   endtask

   // One op into all four DUTs; dut0 checked against hand values, others against the model.
   task automatic do_op(input logic [31:0] aa, input logic [31:0] bb, input logic ci, input logic su,
                        input logic [31:0] es, input logic ec, input logic eo);
      logic [35:0] o;
      logic [34:0] exp;
      @(negedge clk);
      a = aa; b = bb; cin = ci; sub = su;
      iv = 4'hF;
      ordy = 4'hF;
      #1;
      for (int d = 0; d < 4; d++) begin
         o = obs(d);
         tests++;
         if (o[35] !== 1'b1) begin
            fails++;
            $display("FAIL op_in_ready dut%0d: got %b, expected 1", d, o[35]);
         end
      end
      @(negedge clk);
      iv = 4'h0;
      a = 32'hDEAD_BEEF; b = 32'h1234_5678; cin = ~ci; sub = ~su;
      for (int t = 1; t <= 9; t++) begin
         if (t > 1) @(negedge clk);
         for (int d = 0; d < 4; d++) begin
            o = obs(d);
            tests++;
            if (t == nst(d)) begin
               exp = (d == 0) ? {1'b1, ec, eo, es} : {1'b1, mdl(wid(d), aa, bb, ci, su)};
               exp = {exp[34], exp[32], exp[33], exp[31:0]};
               if (d == 0) exp = {1'b1, ec, eo, es};
               else begin
                  exp[33] = mdl(wid(d), aa, bb, ci, su)[32];
                  exp[32] = mdl(wid(d), aa, bb, ci, su)[33];
               end
               if (o[34:0] !== exp) begin
                  fails++;
                  $display("FAIL op_result dut%0d a=%h b=%h cin=%b sub=%b: got v/co/ovf/sum %h, expected %h",
                           d, aa, bb, ci, su, o[34:0], exp);
               end
            end else if (o[34] !== 1'b0) begin
               fails++;
               $display("FAIL op_latency dut%0d t=%0d: out_valid %b, expected 0", d, t, o[34]);
            end
         end
      end
   endtask

   task automatic test_arith();
      do_op(32'h0000_FFFF, 32'h1, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
      do_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      do_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      do_op(32'd5,         32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      do_op(32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
      do_op(32'd10,        32'd3, 1'b1, 1'b1, 32'd6,         1'b1, 1'b0);
   endtask

   task automatic test_back_to_back(input int d);
      logic [35:0] o;
      logic [33:0] m;
      logic [31:0] prev;
      logic        stalled;
      int          sent, recv;
      sent = 0; recv = 0; stalled = 1'b0; prev = '0;
      cin = 1'b0; sub = 1'b0;
      for (int cyc = 0; cyc < 80 && recv < 8; cyc++) begin
         @(negedge clk);
         o = obs(d);
         if (stalled) begin
            tests++;
            if (o[34] !== 1'b1 || o[31:0] !== prev) begin
               fails++;
               $display("FAIL stall_hold dut%0d: got v=%b sum=%h, expected v=1 sum=%h", d, o[34], o[31:0], prev);
            end
         end
         ordy[d] = (cyc % 2 == 0);
         iv[d]   = (sent < 8);
         a = 32'(sent);
         b = 32'(sent) * 32'h0001_0001;
         #1;
         o = obs(d);
         tests++;
         if (o[35] !== !(o[34] && !ordy[d])) begin
            fails++;
            $display("FAIL stream_in_ready dut%0d: got %b with out_valid=%b out_ready=%b", d, o[35], o[34], ordy[d]);
         end
         if (o[34] && ordy[d]) begin
            m = mdl(wid(d), 32'(recv), 32'(recv) * 32'h0001_0001, 1'b0, 1'b0);
            tests++;
            if ({o[33], o[32], o[31:0]} !== {m[32], m[33], m[31:0]}) begin
               fails++;
               $display("FAIL stream_result dut%0d #%0d: got co/ovf/sum %h, expected %h",
                        d, recv, {o[33], o[32], o[31:0]}, {m[32], m[33], m[31:0]});
            end
            recv++;
         end
         if (iv[d] && o[35]) sent++;
         stalled = o[34] && !ordy[d];
         prev = o[31:0];
      end
      iv[d] = 1'b0;
      ordy[d] = 1'b1;
      tests++;
      if (recv != 8) begin
         fails++;
         $display("FAIL stream_count dut%0d: got %0d results, expected 8", d, recv);
      end
      repeat (10) @(negedge clk);
      o = obs(d);
      tests++;
      if (o[34] !== 1'b0) begin
         fails++;
         $display("FAIL stream_no_extra dut%0d: out_valid %b, expected 0", d, o[34]);
      end
   endtask

   task automatic test_reset_midflight();
      logic [35:0] o;
      @(negedge clk);
      ordy = 4'hF;
      iv = 4'hF;
      a = 32'h0000_0003; b = 32'h0000_0004; cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      a = 32'h0000_0005;
      @(negedge clk);
      iv = 4'h0;
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      for (int t = 0; t < 12; t++) begin
         for (int d = 0; d < 4; d++) begin
            o = obs(d);
            tests++;
            if (o[34] !== 1'b0) begin
               fails++;
               $display("FAIL midflight_discard dut%0d t=%0d: out_valid %b, expected 0", d, t, o[34]);
            end
         end
         @(negedge clk);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_arith();
      for (int d = 0; d < 4; d++) test_back_to_back(d);
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
